sha256_padder: RTL

Message front end for the SHA-256 core. Accepts a message as a stream of big-endian 32-bit words, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit length) and emits complete 512-bit blocks with a valid/ready handshake. Its block output feeds the message-schedule load path. first_o and last_o let the core controller re-initialise the hash state and detect when the digest is final.

---
 rtl/sha256_padder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs big-endian 32-bit words into 512-bit blocks and
// appends the 0x80 marker, zero fill and 64-bit bit length of the message.
module sha256_padder #(
   parameter int unsigned LEN_W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  data_i,
   input  logic         valid_i,
   input  logic         last_i,
   input  logic [1:0]   bytes_i,
   output logic         ready_o,
   output logic [511:0] block_o,
   output logic         block_valid_o,
   input  logic         block_ready_i,
   output logic         first_o,
   output logic         last_o
);

   typedef enum logic [2:0] {S_FILL, S_MARK, S_ZERO, S_LEN, S_EMIT} state_t;

   state_t             state, resume, go, go_res, zero_go;
   logic [3:0]         idx;
   logic [LEN_W-1:0]   len, len_add;
   logic               first_flag, pend_last;
   logic               wr_en;
   logic [31:0]        wr_word, tail_word;

   assign ready_o = (state == S_FILL) && !rst;

   // After a marker/zero write at idx: word 15 closes the block, and reaching
   // word 14 hands over to the length words.
   always_comb begin
      zero_go = S_ZERO;
      if (idx == 4'd15)
         zero_go = S_EMIT;
      else if (idx == 4'd13)
         zero_go = S_LEN;
   end

   always_comb begin
      tail_word = {data_i[31:8], 8'h80};
      case (bytes_i)
         2'd1:    tail_word = {data_i[31:24], 8'h80, 16'h0000};
         2'd2:    tail_word = {data_i[31:16], 8'h80, 8'h00};
         default: tail_word = {data_i[31:8], 8'h80};
      endcase
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_word = '0;
      go      = state;
      go_res  = resume;
      len_add = '0;
      case (state)
         S_FILL: begin
            if (valid_i) begin
               wr_en   = 1'b1;
               wr_word = data_i;
               len_add = LEN_W'(32);
               if (last_i && bytes_i != 2'd0) begin
                  wr_word = tail_word;
                  len_add = LEN_W'({bytes_i, 3'b000});
                  go      = zero_go;
                  go_res  = S_ZERO;
               end else if (last_i) begin
                  go      = (idx == 4'd15) ? S_EMIT : S_MARK;
                  go_res  = S_MARK;
               end else begin
                  go      = (idx == 4'd15) ? S_EMIT : S_FILL;
                  go_res  = S_FILL;
               end
            end
         end
         S_MARK: begin
            wr_en   = 1'b1;
            wr_word = 32'h8000_0000;
            go      = zero_go;
            go_res  = S_ZERO;
         end
         S_ZERO: begin
            wr_en   = 1'b1;
            go      = zero_go;
            go_res  = S_ZERO;
         end
         S_LEN: begin
            wr_en   = 1'b1;
            wr_word = idx[0] ? len[31:0] : len[63:32];
            go      = idx[0] ? S_EMIT : S_LEN;
            go_res  = S_FILL;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_FILL;
         resume        <= S_FILL;
         idx           <= '0;
         len           <= '0;
         block_o       <= '0;
         block_valid_o <= 1'b0;
         first_o       <= 1'b0;
         last_o        <= 1'b0;
         pend_last     <= 1'b0;
         first_flag    <= 1'b1;
      end else begin
         if (wr_en) begin
            block_o[{~idx, 5'd0} +: 32] <= wr_word;
            idx    <= idx + 4'd1;
            state  <= go;
            resume <= go_res;
            len    <= len + len_add;
            if (go == S_EMIT) begin
               block_valid_o <= 1'b1;
               first_o       <= first_flag;
               last_o        <= (state == S_LEN);
               pend_last     <= (state == S_LEN);
            end
         end
         if (state == S_EMIT && block_ready_i) begin
            block_valid_o <= 1'b0;
            first_o       <= 1'b0;
            last_o        <= 1'b0;
            idx           <= '0;
            first_flag    <= pend_last;
            if (pend_last) begin
               len       <= '0;
               pend_last <= 1'b0;
               state     <= S_FILL;
            end else begin
               state     <= resume;
            end
         end
      end
   end

endmodule
